// File: rtl/version_store_pkg.sv
// version_pkg: items shared by version_store, its victim selector and the
// downstream priority router.
//   VS_SLICE       - flat-bus slice macro: slot idx of a bus with w-bit fields
//   version_empty  - all-ones "empty" version sentinel for a given tag width
//   vs_state_e     - store FSM states (IDLE, CLEAR)

`ifndef VERSION_PKG_MACROS
`define VERSION_PKG_MACROS
`define VS_SLICE(bus, idx, w) bus[(idx)*(w) +: (w)]
`endif

package version_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } vs_state_e;

    // All-ones tag of the given width. An empty slot reports this value so it
    // never wins a "less than" search downstream.
    function automatic logic [31:0] version_empty(input int unsigned width);
        if (width >= 32) return 32'hFFFF_FFFF;
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage

// File: rtl/version_victim_sel.sv
// version_victim_sel: combinational search over the store's slots.
//   valid_i      - per-slot occupancy
//   versions_i   - flat slot versions, slot i at [i*VERSION_WIDTH +: VERSION_WIDTH]
//   wr_version_i - incoming write tag
//   hit_o/hit_idx_o   - a valid slot already holds wr_version_i, and which
//   free_o/free_idx_o - some slot is free, and the lowest-index free one
//   min_idx_o/min_ver_o - slot with the smallest valid version and its value
//                         (min_ver_o is all-ones when no slot is valid)

module version_victim_sel
    import version_pkg::*;
#(
    parameter  int VERSION_WIDTH = 4,
    parameter  int VERSION_NUM   = 4,
    localparam int IDX_W         = (VERSION_NUM > 1) ? $clog2(VERSION_NUM) : 1
) (
    input  logic [VERSION_NUM-1:0]               valid_i,
    input  logic [VERSION_WIDTH*VERSION_NUM-1:0] versions_i,
    input  logic [VERSION_WIDTH-1:0]             wr_version_i,
    output logic                                 hit_o,
    output logic [IDX_W-1:0]                     hit_idx_o,
    output logic                                 free_o,
    output logic [IDX_W-1:0]                     free_idx_o,
    output logic [IDX_W-1:0]                     min_idx_o,
    output logic [VERSION_WIDTH-1:0]             min_ver_o
);

    localparam logic [VERSION_WIDTH-1:0] VEMPTY = VERSION_WIDTH'(version_empty(VERSION_WIDTH));

    logic min_found;

    always_comb begin
        hit_o      = 1'b0;
        hit_idx_o  = '0;
        free_o     = 1'b0;
        free_idx_o = '0;
        min_idx_o  = '0;
        min_ver_o  = VEMPTY;
        min_found  = 1'b0;
        for (int i = 0; i < VERSION_NUM; i++) begin
            if (valid_i[i] && !hit_o &&
                (`VS_SLICE(versions_i, i, VERSION_WIDTH) == wr_version_i)) begin
                hit_o     = 1'b1;
                hit_idx_o = IDX_W'(i);
            end
            if (!valid_i[i] && !free_o) begin
                free_o     = 1'b1;
                free_idx_o = IDX_W'(i);
            end
            // Strict less-than keeps the lowest index on ties (cannot happen
            // while versions are unique, but keeps the result deterministic).
            if (valid_i[i] && (!min_found ||
                (`VS_SLICE(versions_i, i, VERSION_WIDTH) < min_ver_o))) begin
                min_found = 1'b1;
                min_idx_o = IDX_W'(i);
                min_ver_o = `VS_SLICE(versions_i, i, VERSION_WIDTH);
            end
        end
    end

endmodule

// File: rtl/version_store.sv
// version_store: multi-version register store feeding the priority router.
//   clk, rst           - clock (rising edge), async active-high reset
//   wrValid/wrReady    - write handshake; wrVersion/wrData carry the write
//   clrValid           - pulse starting a slot-by-slot clear sweep
//   versionsOut/dataOut - flat per-slot buses (empty slots: all-ones / zero)
//   slotValid, count   - per-slot occupancy and its registered popcount
//   dropPulse          - one-cycle pulse when an accepted write was discarded

module version_store
    import version_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int VERSION_WIDTH = 4,
    parameter int VERSION_NUM   = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 wrValid,
    output logic                                 wrReady,
    input  logic [VERSION_WIDTH-1:0]             wrVersion,
    input  logic [DATA_WIDTH-1:0]                wrData,
    input  logic                                 clrValid,
    output logic [VERSION_WIDTH*VERSION_NUM-1:0] versionsOut,
    output logic [DATA_WIDTH*VERSION_NUM-1:0]    dataOut,
    output logic [VERSION_NUM-1:0]               slotValid,
    output logic [$clog2(VERSION_NUM+1)-1:0]     count,
    output logic                                 dropPulse
);

    localparam int IDX_W = (VERSION_NUM > 1) ? $clog2(VERSION_NUM) : 1;
    localparam int CNT_W = $clog2(VERSION_NUM+1);
    localparam logic [VERSION_WIDTH-1:0] VEMPTY = VERSION_WIDTH'(version_empty(VERSION_WIDTH));
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VERSION_NUM-1);

    vs_state_e                                 state_q, state_d;
    logic [IDX_W-1:0]                          clr_idx_q, clr_idx_d;
    logic [VERSION_NUM-1:0]                    valid_q, valid_d;
    logic [VERSION_NUM-1:0][VERSION_WIDTH-1:0] ver_q, ver_d;
    logic [VERSION_NUM-1:0][DATA_WIDTH-1:0]    data_q, data_d;
    logic [CNT_W-1:0]                          count_q, count_d;
    logic                                      drop_q, drop_d;

    logic                     hit, free;
    logic [IDX_W-1:0]         hit_idx, free_idx, min_idx;
    logic [VERSION_WIDTH-1:0] min_ver;

    version_victim_sel #(
        .VERSION_WIDTH (VERSION_WIDTH),
        .VERSION_NUM   (VERSION_NUM)
    ) u_victim_sel (
        .valid_i      (valid_q),
        .versions_i   (ver_q),
        .wr_version_i (wrVersion),
        .hit_o        (hit),
        .hit_idx_o    (hit_idx),
        .free_o       (free),
        .free_idx_o   (free_idx),
        .min_idx_o    (min_idx),
        .min_ver_o    (min_ver)
    );

    // A clear request takes priority over a same-cycle write.
    assign wrReady = (state_q == ST_IDLE) && !clrValid;

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        valid_d   = valid_q;
        ver_d     = ver_q;
        data_d    = data_q;
        drop_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (clrValid) begin
                    state_d   = ST_CLEAR;
                    clr_idx_d = '0;
                end else if (wrValid) begin
                    if (wrVersion == VEMPTY) begin
                        drop_d = 1'b1;
                    end else if (hit) begin
                        data_d[hit_idx] = wrData;
                    end else if (free) begin
                        valid_d[free_idx] = 1'b1;
                        ver_d[free_idx]   = wrVersion;
                        data_d[free_idx]  = wrData;
                    end else if (wrVersion > min_ver) begin
                        // Full: evict the oldest (smallest) version.
                        ver_d[min_idx]  = wrVersion;
                        data_d[min_idx] = wrData;
                    end else begin
                        drop_d = 1'b1;
                    end
                end
            end
            ST_CLEAR: begin
                valid_d[clr_idx_q] = 1'b0;
                clr_idx_d          = clr_idx_q + IDX_W'(1);
                if (clr_idx_q == LAST_IDX) begin
                    state_d   = ST_IDLE;
                    clr_idx_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        count_d = '0;
        for (int i = 0; i < VERSION_NUM; i++) begin
            count_d = count_d + CNT_W'(valid_d[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            clr_idx_q <= '0;
            valid_q   <= '0;
            ver_q     <= '0;
            data_q    <= '0;
            count_q   <= '0;
            drop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            valid_q   <= valid_d;
            ver_q     <= ver_d;
            data_q    <= data_d;
            count_q   <= count_d;
            drop_q    <= drop_d;
        end
    end

    for (genvar g = 0; g < VERSION_NUM; g++) begin : g_out
        assign `VS_SLICE(versionsOut, g, VERSION_WIDTH) = valid_q[g] ? ver_q[g] : VEMPTY;
        assign `VS_SLICE(dataOut, g, DATA_WIDTH)        = valid_q[g] ? data_q[g] : '0;
    end

    assign slotValid = valid_q;
    assign count     = count_q;
    assign dropPulse = drop_q;

endmodule

// File: doc/version_store.md
# version_store

Multi-version register store that sits directly upstream of the priority router. Accepts tagged writes (version, data) over a valid/ready handshake and holds up to VERSION_NUM distinct versions, one per slot. When full, it evicts the oldest version. Presents all slots as flat version and data buses that feed the router's version and data inputs. Also supports a multi-cycle clear sweep.

## Interface
- DATA_WIDTH, 32, width of each stored data word
- VERSION_WIDTH, 4, width of a version tag; all-ones is reserved as the "empty" sentinel
- VERSION_NUM, 4, number of slots
- clk  in  1  clock, rising edge
- rst  in  1  reset; asynchronous, active-high
- wrValid  in  1  write request
- wrReady  out  1  store can accept a write this cycle
- wrVersion  in  VERSION_WIDTH  version tag of the write
- wrData  in  DATA_WIDTH  data of the write
- clrValid  in  1  single-cycle pulse that starts a clear sweep
- versionsOut  out  VERSION_WIDTH*VERSION_NUM  slot i occupies bits [i*VERSION_WIDTH +: VERSION_WIDTH]
- dataOut  out  DATA_WIDTH*VERSION_NUM  slot i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- slotValid  out  VERSION_NUM  per-slot occupancy
- count  out  $clog2(VERSION_NUM+1)  number of valid slots
- dropPulse  out  1  one-cycle pulse: an accepted write was discarded

## Operation
- Each slot is a register set {valid, version, data}. Valid versions are unique across slots.
- Invalid slot drives version = all-ones and data = 0 on the outputs, so it never wins a "less than" search downstream.
- FSM states: IDLE and CLEAR.
  - wrReady = (state==IDLE) && !clrValid.
- Accepted write (wrValid && wrReady), resolved in priority order:
  1. wrVersion == all-ones: discarded; dropPulse.
  2. A valid slot already holds wrVersion: that slot's data is overwritten; count unchanged.
  3. A free slot exists: the lowest-index free slot is filled; count+1.
  4. Full, and wrVersion > the smallest stored version: the slot holding the smallest version is replaced; count unchanged.
  5. Full, and wrVersion < all stored versions: discarded; dropPulse.
- Version comparison is unsigned. There is no wrap-around handling; a version counter wrap is the producer's responsibility.
- Clear sequence:
  - clrValid in IDLE moves the FSM to CLEAR with sweep index 0.
  - Each CLEAR cycle invalidates slot[index] and increments the index.
  - After slot VERSION_NUM-1 is invalidated, the FSM returns to IDLE.
  - clrValid during CLEAR is ignored.
  - clrValid and wrValid in the same IDLE cycle: clear wins, the write is not accepted (wrReady is low).
- Reset mid-clear or mid-write: all state returns to reset values immediately.

## Timing
- Reset values:
  - wrReady=1 (IDLE)
  - slotValid=0, count=0, dropPulse=0
  - versionsOut all-ones in every slot, dataOut=0
- Write latency: accepted at edge N; slot, slotValid and count update at edge N, visible from cycle N+1. dropPulse is high in cycle N+1 only.
- Back-to-back writes are accepted every cycle in IDLE. A write that hits a version written in the previous cycle sees the updated state.
- Clear timing:
  - clrValid at edge N gives wrReady=0 from cycle N+1.
  - Slot k is invalid from cycle N+2+k.
  - wrReady=1 again in cycle N+1+VERSION_NUM.
  - Total unavailable window: VERSION_NUM cycles.
- count always equals popcount(slotValid) and is registered, not combinational.

## Structure
- Shared package (version_pkg):
  - VERSION_EMPTY sentinel (all-ones) function
  - FSM state encoding (IDLE, CLEAR)
  - flat-bus slice helper macros shared with the router
- Sub-module version_victim_sel: combinational search over slots. It returns a hit flag and index, a free flag and lowest free index, and the min-version index and value. It is instantiated once; everything else stays in the top module.

## Test plan
All scenarios use DATA_WIDTH=32, VERSION_WIDTH=4, VERSION_NUM=4.
- Reset, then idle: versionsOut=16'hFFFF, dataOut=0, count=0, wrReady=1.
- Write v3/0xA, v5/0xB, v1/0xC, v7/0xD: slots 0..3 = {3,5,1,7}, count=4. Then write v5/0xEE: slot1 data=0xEE, count=4, no drop.
- Full {3,5,1,7}: write v9/0x99 gives slot2 = v9/0x99. Then write v0/0x11: dropPulse for one cycle, contents unchanged.
- Write vF/0x1234 to an empty store: dropPulse, count=0.
- Full store, clrValid pulse:
  - wrReady low for exactly 4 cycles.
  - slotValid goes 1110, 1100, 1000, 0000 on successive cycles; count follows 3, 2, 1, 0.
  - Simultaneous wrValid is not accepted.
- Assert rst during cycle 2 of a clear: all outputs at reset values next cycle, FSM in IDLE. A write on the cycle after rst deasserts is accepted.
